// File: rtl/module_pipereg_skid.sv
// Elastic valid/ready pipeline register with a two-entry skid buffer.
// Upstream ready comes straight from a flop; flush drops everything and presents a bubble.
module module_pipereg_skid #(
   parameter int          WIDTH     = 32,
   parameter logic [31:0] NOP_VALUE = 32'h0000_0013
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             s_valid_i,
   output logic             s_ready_o,
   input  logic [WIDTH-1:0] s_data_i,
   output logic             m_valid_o,
   input  logic             m_ready_i,
   output logic [WIDTH-1:0] m_data_o,
   output logic [1:0]       occupancy_o
);

   // Bubble value fitted to the payload width: low bits kept, upper bits zero.
   function automatic logic [WIDTH-1:0] fit_nop();
      logic [WIDTH-1:0] v;
      v = '0;
      for (int i = 0; i < WIDTH && i < 32; i++) begin
         v[i] = NOP_VALUE[i];
      end
      return v;
   endfunction

   localparam logic [WIDTH-1:0] NOP_W = fit_nop();

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] main_reg, main_next;
   logic [WIDTH-1:0] skid_reg, skid_next;
   logic             m_valid_reg;
   logic             s_ready_reg;
   logic             in_xfer;
   logic             out_xfer;

   assign in_xfer  = s_valid_i & s_ready_reg;
   assign out_xfer = m_valid_reg & m_ready_i;

   always_comb begin
      state_next = state_reg;
      main_next  = main_reg;
      skid_next  = skid_reg;
      if (flush_i) begin
         state_next = ST_EMPTY;
         main_next  = NOP_W;
         skid_next  = NOP_W;
      end else begin
         case (state_reg)
            ST_EMPTY: begin
               if (in_xfer) begin
                  state_next = ST_ONE;
                  main_next  = s_data_i;
               end
            end
            ST_ONE: begin
               if (in_xfer && out_xfer) begin
                  main_next = s_data_i;
               end else if (in_xfer) begin
                  state_next = ST_TWO;
                  skid_next  = s_data_i;
               end else if (out_xfer) begin
                  state_next = ST_EMPTY;
                  main_next  = NOP_W;
               end
            end
            ST_TWO: begin
               // Ready is low here, so only the drain side can move.
               if (out_xfer) begin
                  state_next = ST_ONE;
                  main_next  = skid_reg;
                  skid_next  = NOP_W;
               end
            end
            default: begin
               state_next = ST_EMPTY;
               main_next  = NOP_W;
               skid_next  = NOP_W;
            end
         endcase
      end
   end

   // Handshake outputs are registered from the next state so they match it exactly.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg   <= ST_EMPTY;
         main_reg    <= NOP_W;
         skid_reg    <= NOP_W;
         m_valid_reg <= 1'b0;
         s_ready_reg <= 1'b1;
      end else begin
         state_reg   <= state_next;
         main_reg    <= main_next;
         skid_reg    <= skid_next;
         m_valid_reg <= (state_next != ST_EMPTY);
         s_ready_reg <= (state_next != ST_TWO);
      end
   end

   assign s_ready_o   = s_ready_reg;
   assign m_valid_o   = m_valid_reg;
   assign m_data_o    = main_reg;
   assign occupancy_o = state_reg;

endmodule

// File: tb/tb_module_pipereg_skid.sv
// Bench for module_pipereg_skid: directed scenarios on a 32-bit instance, random traffic on an 8-bit one,
// both checked every cycle against a queue model of the stage contents.
module tb_module_pipereg_skid;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instance A: default parameters
   logic        rst_a = 1'b1, flush_a = 1'b0, sv_a = 1'b0, mr_a = 1'b0;
   logic [31:0] sd_a = '0;
   logic        sr_a, mv_a;
   logic [31:0] md_a;
   logic [1:0]  occ_a;

   // Instance B: WIDTH=8, NOP_VALUE=0
   logic        rst_b = 1'b1, flush_b = 1'b0, sv_b = 1'b0, mr_b = 1'b0;
   logic [7:0]  sd_b = '0;
   logic        sr_b, mv_b;
   logic [7:0]  md_b;
   logic [1:0]  occ_b;

   module_pipereg_skid dut_a (
      .clk_i(clk), .rst_i(rst_a), .flush_i(flush_a),
      .s_valid_i(sv_a), .s_ready_o(sr_a), .s_data_i(sd_a),
      .m_valid_o(mv_a), .m_ready_i(mr_a), .m_data_o(md_a), .occupancy_o(occ_a)
   );

   module_pipereg_skid #(.WIDTH(8), .NOP_VALUE(32'h0)) dut_b (
      .clk_i(clk), .rst_i(rst_b), .flush_i(flush_b),
      .s_valid_i(sv_b), .s_ready_o(sr_b), .s_data_i(sd_b),
      .m_valid_o(mv_b), .m_ready_i(mr_b), .m_data_o(md_b), .occupancy_o(occ_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the stage is a FIFO of at most two words; anything else follows from its contents.
   logic [31:0] qa[$];
   logic [7:0]  qb[$];
   bit init_a = 1'b0, init_b = 1'b0;

   always @(posedge clk) begin : model_a
      bit inx, outx;
      if (rst_a) begin
         qa.delete();
         init_a = 1'b1;
      end else begin
         inx  = sv_a && (qa.size() < 2);
         outx = mr_a && (qa.size() > 0);
         if (flush_a) qa.delete();
         else begin
            if (outx) void'(qa.pop_front());
            if (inx) qa.push_back(sd_a);
         end
      end
   end

   always @(posedge clk) begin : model_b
      bit inx, outx;
      if (rst_b) begin
         qb.delete();
         init_b = 1'b1;
      end else begin
         inx  = sv_b && (qb.size() < 2);
         outx = mr_b && (qb.size() > 0);
         if (flush_b) qb.delete();
         else begin
            if (outx) void'(qb.pop_front());
            if (inx) qb.push_back(sd_b);
         end
      end
   end

   // Stall-stability property on B: data must not move while stalled.
   logic       hold_prev = 1'b0;
   logic [7:0] md_prev = '0;
   always @(posedge clk) begin
      hold_prev <= mv_b && !mr_b && !rst_b && !flush_b;
      md_prev   <= md_b;
   end

   always @(negedge clk) begin
      if (init_a) begin
         chk("a_valid", {31'b0, mv_a}, {31'b0, qa.size() > 0});
         chk("a_ready", {31'b0, sr_a}, {31'b0, qa.size() < 2});
         chk("a_occ", {30'b0, occ_a}, qa.size());
         chk("a_data", md_a, (qa.size() > 0) ? qa[0] : 32'h0000_0013);
      end
      if (init_b) begin
         chk("b_valid", {31'b0, mv_b}, {31'b0, qb.size() > 0});
         chk("b_ready", {31'b0, sr_b}, {31'b0, qb.size() < 2});
         chk("b_occ", {30'b0, occ_b}, qb.size());
         chk("b_data", {24'b0, md_b}, (qb.size() > 0) ? {24'b0, qb[0]} : 32'h0);
         if (occ_b == 2'd2) chk("b_ready_in_two", {31'b0, sr_b}, 32'd0);
         if (hold_prev) chk("b_stable", {24'b0, md_b}, {24'b0, md_prev});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lit_a(input string tag, input logic [31:0] d, input logic v,
                        input logic r, input logic [1:0] o);
      chk({tag, "_data"}, md_a, d);
      chk({tag, "_valid"}, {31'b0, mv_a}, {31'b0, v});
      chk({tag, "_ready"}, {31'b0, sr_a}, {31'b0, r});
      chk({tag, "_occ"}, {30'b0, occ_a}, {30'b0, o});
   endtask

   initial begin
      // Reset then stream
      rst_a = 1'b1;
      tick(); tick();
      lit_a("rst", 32'h13, 1'b0, 1'b1, 2'd0);
      rst_a = 1'b0; mr_a = 1'b1; sv_a = 1'b1;
      sd_a = 32'h11; tick(); lit_a("st11", 32'h11, 1'b1, 1'b1, 2'd1);
      sd_a = 32'h22; tick(); lit_a("st22", 32'h22, 1'b1, 1'b1, 2'd1);
      sd_a = 32'h33; tick(); lit_a("st33", 32'h33, 1'b1, 1'b1, 2'd1);
      sv_a = 1'b0;   tick(); lit_a("stend", 32'h13, 1'b0, 1'b1, 2'd0);

      // Backpressure into the skid register
      mr_a = 1'b0; sv_a = 1'b1;
      sd_a = 32'hA; tick(); lit_a("bpA", 32'hA, 1'b1, 1'b1, 2'd1);
      sd_a = 32'hB; tick(); lit_a("bpB", 32'hA, 1'b1, 1'b0, 2'd2);
      sd_a = 32'hC; tick(); lit_a("bpC", 32'hA, 1'b1, 1'b0, 2'd2);
      mr_a = 1'b1;  tick(); lit_a("drB", 32'hB, 1'b1, 1'b1, 2'd1);
      tick();               lit_a("drC", 32'hC, 1'b1, 1'b1, 2'd1);
      sv_a = 1'b0;  tick(); lit_a("drend", 32'h13, 1'b0, 1'b1, 2'd0);

      // Flush while full, with a word offered in the same cycle
      mr_a = 1'b0; sv_a = 1'b1;
      sd_a = 32'h5; tick();
      sd_a = 32'h6; tick(); lit_a("fl_full", 32'h5, 1'b1, 1'b0, 2'd2);
      flush_a = 1'b1; sd_a = 32'h7; tick();
      lit_a("fl", 32'h13, 1'b0, 1'b1, 2'd0);
      flush_a = 1'b0; sv_a = 1'b0; mr_a = 1'b1; tick();
      lit_a("fl_after", 32'h13, 1'b0, 1'b1, 2'd0);

      // Simultaneous accept and drain in ONE
      mr_a = 1'b0; sv_a = 1'b1; sd_a = 32'h1; tick();
      lit_a("sim1", 32'h1, 1'b1, 1'b1, 2'd1);
      mr_a = 1'b1; sd_a = 32'h2; tick();
      lit_a("sim2", 32'h2, 1'b1, 1'b1, 2'd1);
      sv_a = 1'b0; tick();

      // Reset while full, overriding flush and an offered word
      mr_a = 1'b0; sv_a = 1'b1;
      sd_a = 32'h8; tick();
      sd_a = 32'h9; tick(); lit_a("rm_full", 32'h8, 1'b1, 1'b0, 2'd2);
      rst_a = 1'b1; flush_a = 1'b1; sd_a = 32'hAA; tick();
      lit_a("rm", 32'h13, 1'b0, 1'b1, 2'd0);
      rst_a = 1'b0; flush_a = 1'b0; sv_a = 1'b0; tick();
      lit_a("rm_after", 32'h13, 1'b0, 1'b1, 2'd0);

      // Randomised traffic on the narrow instance
      rst_b = 1'b1; tick(); tick();
      rst_b = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         sv_b    = ($urandom_range(0, 3) != 0);
         sd_b    = 8'($urandom);
         case ((i / 1000) % 3)
            0:       mr_b = ($urandom_range(0, 3) != 0);
            1:       mr_b = ($urandom_range(0, 3) == 0);
            default: mr_b = 1'b1;
         endcase
         flush_b = ($urandom_range(0, 99) == 0);
         rst_b   = ($urandom_range(0, 999) == 0);
         tick();
      end
      sv_b = 1'b0; flush_b = 1'b0; rst_b = 1'b0; mr_b = 1'b1;
      tick(); tick(); tick();
      chk("b_drained", {30'b0, occ_b}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/module_pipereg_skid.md
Name: module_pipereg_skid

Overview:
Elastic pipeline register for the RV32I pipeline. It replaces enable/clear stage registers on paths that need backpressure, using a valid/ready handshake with a 2-entry skid buffer. Upstream ready is registered, so no combinational ready path crosses the stage. A flush discards the contents and presents a configurable bubble value downstream, for example the NOP encoding.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- NOP_VALUE, 32'h00000013, value driven on m_data_o whenever the stage is empty or flushed; truncated/zero-extended to WIDTH.

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- flush_i  input  1  discard all held and incoming data this cycle.
- s_valid_i  input  1  upstream data valid.
- s_ready_o  output  1  stage can accept; driven directly from a flop.
- s_data_i  input  WIDTH  upstream payload.
- m_valid_o  output  1  downstream data valid.
- m_ready_i  input  1  downstream accepts.
- m_data_o  output  WIDTH  downstream payload (main register).
- occupancy_o  output  2  entries held: 0, 1 or 2.

Behaviour:
- Storage: main register (drives m_data_o) and skid register. State is EMPTY, ONE or TWO, and occupancy_o equals the state encoding (0/1/2).
- Transfer definitions: in_xfer = s_valid_i & s_ready_o; out_xfer = m_valid_o & m_ready_i.
- Reset (rst_i high at clock edge):
  - state=EMPTY, m_valid_o=0, s_ready_o=1, m_data_o=NOP_VALUE, skid=NOP_VALUE.
  - Reset overrides flush and all transfers in that cycle.
  - Data presented while rst_i is high is never accepted.
- Priority order: rst_i, then flush_i, then the handshake.
- Flush (rst_i low, flush_i high):
  - Next state is EMPTY from any state.
  - m_valid_o=0, m_data_o=NOP_VALUE, s_ready_o=1.
  - A same-cycle in_xfer is dropped and a same-cycle out_xfer is still considered consumed; no data survives.
- Outputs per state: m_valid_o = (state != EMPTY); s_ready_o = (state != TWO). Both are registered and take their values from the next state.
- EMPTY:
  - in_xfer -> ONE; main<=s_data_i.
  - Otherwise hold, with m_data_o=NOP_VALUE.
- ONE:
  - in_xfer & out_xfer -> ONE; main<=s_data_i.
  - in_xfer & !out_xfer -> TWO; skid<=s_data_i, main holds.
  - !in_xfer & out_xfer -> EMPTY; main<=NOP_VALUE.
  - Neither -> hold.
- TWO:
  - No input can be accepted because s_ready_o=0.
  - out_xfer -> ONE; main<=skid, skid<=NOP_VALUE.
  - Otherwise hold.
- Ordering: strict FIFO; no loss, duplication or reordering outside flush/reset.
- Latency: 1 cycle from in_xfer in EMPTY to m_valid_o=1 with that data.
- Throughput: one word per cycle sustained while m_ready_i=1.
- Stability: while m_valid_o=1 and m_ready_i=0, m_data_o and m_valid_o hold stable across cycles.
- Held values: s_data_i is sampled only on in_xfer. The skid register is don't-care outside TWO but is reset/cleared to NOP_VALUE as stated.
- m_ready_i may be high while m_valid_o=0; this has no effect.

Test Plan:
- Reset then stream: rst_i 1 for 2 cycles, release. Drive s_valid_i=1 with data 0x11,0x22,0x33 on consecutive cycles, m_ready_i=1 throughout.
  -> s_ready_o=1 throughout; m_data_o shows 0x11,0x22,0x33 on the cycles after each accept, with m_valid_o=1; occupancy_o=1; then m_data_o returns to 0x00000013 with m_valid_o=0.
- Backpressure/skid: m_ready_i=0; push 0xA, then 0xB.
  -> After 2 accepts, occupancy_o=2 and s_ready_o=0; 0xC held on the input is not accepted.
  -> Raise m_ready_i: 0xA, then 0xB, then 0xC are delivered in order with no gap once s_ready_o returns to 1.
- Flush at full: occupancy_o=2 holding 0x5,0x6; assert flush_i one cycle with s_valid_i=1 and data 0x7.
  -> Next cycle: occupancy_o=0, m_valid_o=0, m_data_o=0x00000013, s_ready_o=1; 0x5/0x6/0x7 never appear.
- Simultaneous in/out in ONE: hold 0x1; same cycle s_valid_i=1 with data 0x2 and m_ready_i=1.
  -> Next cycle m_data_o=0x2, occupancy_o=1.
- Reset mid-operation: occupancy_o=2; assert rst_i together with flush_i and s_valid_i.
  -> Next cycle all outputs are at reset values; no data accepted.
- Randomised valid/ready, 10k cycles, WIDTH=8 and NOP_VALUE=0: the scoreboard sees in-order, lossless delivery; s_ready_o is never asserted in TWO; m_data_o is stable whenever m_valid_o=1 and m_ready_i=0.
